// File: rtl/riscv_reg_writeback_if.sv
// Writeback bundle: two result sources (ALU=A, LSU=B) in, one register-file write port out.
interface riscv_reg_writeback_if #(
  parameter int BUS_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_DEPTH      = 32,
  parameter int FIFO_DEPTH     = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                      i_A_VALID;
  logic [REG_ADDR_WIDTH-1:0] i_A_RD;
  logic [BUS_WIDTH-1:0]      i_A_DATA;
  logic                      o_A_READY;
  logic                      i_B_VALID;
  logic [REG_ADDR_WIDTH-1:0] i_B_RD;
  logic [BUS_WIDTH-1:0]      i_B_DATA;
  logic                      o_B_READY;
  logic [REG_ADDR_WIDTH-1:0] o_WRR;
  logic [BUS_WIDTH-1:0]      o_WRDATA;
  logic                      o_WREnable;
  logic [REG_DEPTH-1:0]      o_PENDING;
  logic [CNT_W-1:0]          o_COUNT;
  logic                      o_FULL;

  modport slave (
    input  i_A_VALID, i_A_RD, i_A_DATA, i_B_VALID, i_B_RD, i_B_DATA,
    output o_A_READY, o_B_READY, o_WRR, o_WRDATA, o_WREnable, o_PENDING, o_COUNT, o_FULL
  );

  modport master (
    output i_A_VALID, i_A_RD, i_A_DATA, i_B_VALID, i_B_RD, i_B_DATA,
    input  o_A_READY, o_B_READY, o_WRR, o_WRDATA, o_WREnable, o_PENDING, o_COUNT, o_FULL
  );
endinterface

// File: rtl/riscv_reg_writeback.sv
// Register-file write front end: round-robin accept of ALU/LSU results into an in-order
// queue, one register write per cycle, plus a pending-write mask for issue stalls.
module riscv_reg_writeback #(
  parameter int BUS_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_DEPTH      = 32,
  parameter int FIFO_DEPTH     = 4
) (
  input logic                  i_CLK,
  input logic                  i_RST_N,
  riscv_reg_writeback_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {RR_A = 1'b0, RR_B = 1'b1} rr_e;

  rr_e                                        rr_q, rr_d;
  logic [FIFO_DEPTH-1:0][REG_ADDR_WIDTH-1:0]  q_rd;
  logic [FIFO_DEPTH-1:0][BUS_WIDTH-1:0]       q_data;
  logic [PTR_W-1:0]                           wr_ptr, rd_ptr;
  logic [CNT_W-1:0]                           count_q;
  logic                                       wren_q;
  logic [REG_ADDR_WIDTH-1:0]                  wrr_q;
  logic [BUS_WIDTH-1:0]                       wrdata_q;

  logic                      full, grant_a, grant_b, a_ready, b_ready;
  logic                      acc, enq, deq;
  logic [REG_ADDR_WIDTH-1:0] acc_rd;
  logic [BUS_WIDTH-1:0]      acc_data;
  logic [REG_DEPTH-1:0]      pend;
  logic [PTR_W-1:0]          off;

  // Full blocks acceptance outright; a same-cycle dequeue does not open a slot early.
  always_comb begin
    full     = (count_q == CNT_W'(FIFO_DEPTH));
    grant_a  = bus.i_A_VALID && (!bus.i_B_VALID || rr_q == RR_A);
    grant_b  = bus.i_B_VALID && (!bus.i_A_VALID || rr_q == RR_B);
    a_ready  = grant_a && !full;
    b_ready  = grant_b && !full;
    acc      = a_ready || b_ready;
    acc_rd   = a_ready ? bus.i_A_RD   : bus.i_B_RD;
    acc_data = a_ready ? bus.i_A_DATA : bus.i_B_DATA;
    enq      = acc && (acc_rd != '0);
    deq      = (count_q != '0);
  end

  // Round-robin pointer only moves when both sources competed and one was taken.
  always_comb begin
    rr_d = rr_q;
    if (bus.i_A_VALID && bus.i_B_VALID && acc)
      rr_d = (rr_q == RR_A) ? RR_B : RR_A;
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) rr_q <= RR_A;
    else          rr_q <= rr_d;
  end

  always_ff @(posedge i_CLK) begin
    if (enq) begin
      q_rd[wr_ptr]   <= acc_rd;
      q_data[wr_ptr] <= acc_data;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      wren_q   <= 1'b0;
      wrr_q    <= '0;
      wrdata_q <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + CNT_W'(enq) - CNT_W'(deq);
      wren_q  <= deq;
      if (deq) begin
        wrr_q    <= q_rd[rd_ptr];
        wrdata_q <= q_data[rd_ptr];
      end
    end
  end

  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    pend = '0;
    off  = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr;
      if ({1'b0, off} < count_q) pend[q_rd[i]] = 1'b1;
    end
    if (wren_q) pend[wrr_q] = 1'b1;
    pend[0] = 1'b0;
  end

  assign bus.o_A_READY  = a_ready;
  assign bus.o_B_READY  = b_ready;
  assign bus.o_WRR      = wrr_q;
  assign bus.o_WRDATA   = wrdata_q;
  assign bus.o_WREnable = wren_q;
  assign bus.o_PENDING  = pend;
  assign bus.o_COUNT    = count_q;
  assign bus.o_FULL     = full;
endmodule
